// File: rtl/tex_texel_gather.sv
// Texel gather: issues one memory read per active quad-footprint slot, collects
// out-of-order responses by tag and hands the raw texels to the sampler.
`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 3
`endif
`ifndef TEX_BLEND_FRAC
`define TEX_BLEND_FRAC 8
`endif

module tex_texel_gather #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned REQ_INFOW = 1,
  parameter int unsigned ADDRW     = 32,
  parameter int unsigned TAGW      = $clog2(4*NUM_LANES)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    req_valid,
  input  logic [`TEX_FORMAT_BITS-1:0]             req_format,
  input  logic [NUM_LANES*2*`TEX_BLEND_FRAC-1:0]  req_blends,
  input  logic [NUM_LANES*4*ADDRW-1:0]            req_addrs,
  input  logic [NUM_LANES-1:0]                    req_mask,
  input  logic [REQ_INFOW-1:0]                    req_info,
  output logic                                    req_ready,
  output logic                                    mem_req_valid,
  output logic [ADDRW-1:0]                        mem_req_addr,
  output logic [TAGW-1:0]                         mem_req_tag,
  input  logic                                    mem_req_ready,
  input  logic                                    mem_rsp_valid,
  input  logic [31:0]                             mem_rsp_data,
  input  logic [TAGW-1:0]                         mem_rsp_tag,
  output logic                                    mem_rsp_ready,
  output logic                                    rsp_valid,
  output logic [`TEX_FORMAT_BITS-1:0]             rsp_format,
  output logic [NUM_LANES*2*`TEX_BLEND_FRAC-1:0]  rsp_blends,
  output logic [NUM_LANES*4*32-1:0]               rsp_data,
  output logic [REQ_INFOW-1:0]                    rsp_info,
  input  logic                                    rsp_ready
);
  localparam int unsigned NSLOT = 4*NUM_LANES;
  localparam int unsigned CNTW  = TAGW + 1;
  localparam int unsigned LANEW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned FMTW  = `TEX_FORMAT_BITS;
  localparam int unsigned BLNDW = NUM_LANES*2*`TEX_BLEND_FRAC;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                     state, state_n;
  logic [FMTW-1:0]            fmt_q;
  logic [BLNDW-1:0]           blends_q;
  logic [NSLOT*ADDRW-1:0]     addrs_q;
  logic [NUM_LANES-1:0]       mask_q;
  logic [REQ_INFOW-1:0]       info_q;
  logic [NSLOT*32-1:0]        data_q;
  logic [NSLOT-1:0]           got_q;
  logic [CNTW-1:0]            iss_cnt, rcv_cnt, total_q, req_total;
  logic [TAGW-1:0]            ptr_q, ptr_nxt;
  logic [LANEW-1:0]           cur_lane, nxt_lane, first_lane, rsp_lane;
  logic                       req_fire, iss_fire, rsp_fire, last_iss, rcv_done;

  assign req_fire = (state == S_IDLE) && req_valid;
  assign iss_fire = (state == S_ISSUE) && mem_req_ready;
  assign rsp_fire = mem_rsp_valid && mem_rsp_ready;
  assign last_iss = (iss_cnt == total_q - CNTW'(1));
  assign rcv_done = ((rcv_cnt + CNTW'(rsp_fire)) == total_q);
  assign cur_lane = LANEW'(ptr_q >> 2);
  assign rsp_lane = LANEW'(mem_rsp_tag >> 2);

  // Slot count of the incoming request and its first active lane
  always_comb begin
    req_total  = '0;
    first_lane = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (req_mask[i]) begin
        req_total  = req_total + CNTW'(4);
        first_lane = LANEW'(i);
      end
    end
  end

  // Pointer step: next corner, or corner 0 of the next active lane
  always_comb begin
    nxt_lane = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if ((LANEW'(i) > cur_lane) && mask_q[i]) nxt_lane = LANEW'(i);
    end
    if (ptr_q[1:0] != 2'b11) ptr_nxt = ptr_q + TAGW'(1);
    else                     ptr_nxt = TAGW'(TAGW'(nxt_lane) << 2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req_valid) state_n = (req_mask == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (iss_fire && last_iss) state_n = rcv_done ? S_DONE : S_WAIT;
      S_WAIT:  if (rcv_done) state_n = S_DONE;
      S_DONE:  if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_rsp_ready <= 1'b0;
      rsp_valid     <= 1'b0;
    end else begin
      req_ready     <= (state_n == S_IDLE);
      mem_req_valid <= (state_n == S_ISSUE);
      mem_rsp_ready <= (state_n == S_ISSUE) || (state_n == S_WAIT);
      rsp_valid     <= (state_n == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fmt_q    <= '0;
      blends_q <= '0;
      addrs_q  <= '0;
      mask_q   <= '0;
      info_q   <= '0;
      data_q   <= '0;
      got_q    <= '0;
      iss_cnt  <= '0;
      rcv_cnt  <= '0;
      total_q  <= '0;
      ptr_q    <= '0;
    end else if (req_fire) begin
      fmt_q    <= req_format;
      blends_q <= req_blends;
      addrs_q  <= req_addrs;
      mask_q   <= req_mask;
      info_q   <= req_info;
      data_q   <= '0;
      got_q    <= '0;
      iss_cnt  <= '0;
      rcv_cnt  <= '0;
      total_q  <= req_total;
      ptr_q    <= TAGW'(TAGW'(first_lane) << 2);
    end else begin
      if (iss_fire) begin
        iss_cnt <= iss_cnt + CNTW'(1);
        ptr_q   <= ptr_nxt;
      end
      if (rsp_fire) begin
        data_q[int'(mem_rsp_tag)*32 +: 32] <= mem_rsp_data;
        got_q[mem_rsp_tag]                 <= 1'b1;
        rcv_cnt                            <= rcv_cnt + CNTW'(1);
      end
    end
  end

  assign mem_req_addr = addrs_q[int'(ptr_q)*int'(ADDRW) +: ADDRW];
  assign mem_req_tag  = ptr_q;
  assign rsp_format   = fmt_q;
  assign rsp_blends   = blends_q;
  assign rsp_data     = data_q;
  assign rsp_info     = info_q;

  // Responses only while collecting, only for active, not-yet-returned slots
  assert property (@(posedge clk) disable iff (!reset)
    mem_rsp_valid |-> (mem_rsp_ready && mask_q[rsp_lane] && !got_q[mem_rsp_tag]))
    else $error("tex_texel_gather: protocol error on memory response tag %0d", mem_rsp_tag);

endmodule
